alu_seq_ctrl: RTL
=================

Name: alu_seq_ctrl

Overview:
- Sequencing and accumulator stage wrapped around the combinational 4-bit ALU/shifter.
- Accepts commands over a valid/ready handshake and drives the ALU operand and mode inputs (a, b, m) from registers.
- Captures the ALU result r and overflow into an accumulator, iterating the same mode N times for repeated shifts/increments.
- Returns the final accumulator and a sticky overflow flag on a result handshake.

Parameters:
- CNT_W, 3, width of the repeat count; max iterations per REPEAT = 2**CNT_W - 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_op  in  2  00 LOAD, 01 EXEC, 10 REPEAT, 11 CLEAR.
- cmd_mode  in  4  ALU mode m to apply; ignored for LOAD/CLEAR.
- cmd_data  in  4  LOAD value or ALU b operand.
- cmd_cnt  in  CNT_W  iteration count for REPEAT.
- alu_a  out  4  ALU a input; always equals acc.
- alu_b  out  4  ALU b input; registered operand.
- alu_m  out  4  ALU mode input; registered mode.
- alu_r  in  4  ALU result.
- alu_ovf  in  1  ALU overflow (carry/no-borrow); meaningful only when alu_m is 4'b0000 or 4'b0001.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  4  final accumulator value.
- res_ovf  out  1  sticky overflow for the command.

Behaviour:
- Reset values:
  - state = IDLE.
  - acc, alu_b, alu_m, cnt = 0.
  - res_valid = 0, res_ovf = 0, cmd_ready = 1.
  - Reset mid-command aborts it; no result is produced.
- States:
  - IDLE: cmd_ready = 1; a command is accepted when cmd_valid & cmd_ready.
  - RUN: one ALU evaluation per cycle.
  - DONE: res_valid = 1, held until res_ready.
- Command handling at acceptance:
  - LOAD: acc <= cmd_data, ovf <= 0, go to DONE.
  - CLEAR: acc <= 0, ovf <= 0, go to DONE.
  - EXEC: alu_b <= cmd_data, alu_m <= cmd_mode, cnt <= 1, ovf <= 0, go to RUN.
  - REPEAT: alu_b <= cmd_data, alu_m <= cmd_mode, cnt <= cmd_cnt, ovf <= 0.
    - cmd_cnt == 0 goes straight to DONE with acc unchanged.
    - Otherwise go to RUN.
- RUN, each cycle:
  - acc <= alu_r.
  - If alu_m is 0000 or 0001, ovf <= ovf | alu_ovf; otherwise alu_ovf is ignored (it may be Z).
  - cnt <= cnt - 1; when cnt == 1, go to DONE.
- Latency:
  - LOAD/CLEAR: res_valid is high in the cycle after acceptance.
  - EXEC: res_valid is high 2 cycles after acceptance.
  - REPEAT n (n ≥ 1): res_valid is high n+1 cycles after acceptance.
- DONE:
  - res_data = acc, res_ovf = ovf.
  - Leave DONE on the cycle res_valid & res_ready is seen, returning to IDLE.
  - res_valid must stay stable while res_ready is low.
- cmd_ready is low in RUN and DONE, so there is no command pipelining and no queued commands; cmd_valid in those states is ignored.
- Arithmetic: all 4-bit; wrap-around is whatever the ALU produces. The block does no arithmetic of its own except the counter decrement.
- alu_a/alu_b/alu_m stay at their last values in IDLE and DONE; no X values are driven.

Decomposition:
- Shared package holds:
  - the opcode constants OP_LOAD/OP_EXEC/OP_REPEAT/OP_CLEAR;
  - the state encoding (IDLE/RUN/DONE);
  - named ALU mode constants (M_ADD = 4'b0000, M_SUB = 4'b0001, M_INC = 4'b0110, M_ROR = 4'b1101, M_ROL = 4'b1110).
- No sub-module: a single FSM plus datapath. The bench instantiates this block together with the ALU.

Test Plan:
- Reset, then LOAD 4'd5, then EXEC M_ADD b = 3 -> res_data = 8, res_ovf = 0; res_valid rises 2 cycles after acceptance.
- LOAD 9, then EXEC M_ADD b = 9 -> res_data = 4'd2, res_ovf = 1.
- LOAD 4'b0001, then REPEAT M_ROR cnt = 2 -> res_data = 4'b0100, res_ovf = 0 (Z on alu_ovf is ignored); latency is 3 cycles.
- LOAD 4'd14, then REPEAT M_INC cnt = 0 -> DONE the next cycle with res_data = 14. Then REPEAT M_INC cnt = 3 -> res_data = 4'd1 (wrap), res_ovf = 0.
- Hold res_ready = 0 for 5 cycles in DONE -> res_valid and res_data stay stable, cmd_ready = 0, and a cmd_valid pulse is ignored. Raise res_ready -> IDLE next cycle.
- Assert rst during RUN of REPEAT cnt = 7 -> the next cycle shows IDLE, acc = 0, res_valid = 0, cmd_ready = 1, and no result is emitted.

Source files
------------

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU sequencing/accumulator stage: opcodes, FSM states,
// ALU mode names.
package alu_seq_ctrl_pkg;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_EXEC   = 2'b01;
  localparam logic [1:0] OP_REPEAT = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [3:0] M_ADD = 4'b0000;
  localparam logic [3:0] M_SUB = 4'b0001;
  localparam logic [3:0] M_INC = 4'b0110;
  localparam logic [3:0] M_ROR = 4'b1101;
  localparam logic [3:0] M_ROL = 4'b1110;

  // Only add/sub drive a meaningful carry; every other mode may leave it floating.
  function automatic logic ovf_mode(input logic [3:0] m);
    return (m == M_ADD) || (m == M_SUB);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Command and result handshakes of the ALU sequencer; master issues commands and
// consumes results, slave is the sequencer.
interface alu_seq_ctrl_if #(
  parameter int unsigned CNT_W = 3
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [3:0]       cmd_mode;
  logic [3:0]       cmd_data;
  logic [CNT_W-1:0] cmd_cnt;
  logic             res_valid;
  logic             res_ready;
  logic [3:0]       res_data;
  logic             res_ovf;

  modport master (
    output cmd_valid, cmd_op, cmd_mode, cmd_data, cmd_cnt, res_ready,
    input  cmd_ready, res_valid, res_data, res_ovf
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_mode, cmd_data, cmd_cnt, res_ready,
    output cmd_ready, res_valid, res_data, res_ovf
  );

endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer/accumulator around the combinational 4-bit ALU: feeds it from registers and
// iterates one mode N times, returning the accumulator and a sticky overflow.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_seq_ctrl_if.slave        bus,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [3:0]           alu_m,
  input  logic [3:0]           alu_r,
  input  logic                 alu_ovf
);

  state_e           state_q, state_d;
  logic [3:0]       acc_q, acc_d;
  logic [3:0]       b_q, b_d;
  logic [3:0]       m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      b_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          ovf_d = 1'b0;
          case (bus.cmd_op)
            OP_LOAD: begin
              acc_d   = bus.cmd_data;
              state_d = StDone;
            end
            OP_CLEAR: begin
              acc_d   = '0;
              state_d = StDone;
            end
            OP_EXEC: begin
              b_d     = bus.cmd_data;
              m_d     = bus.cmd_mode;
              cnt_d   = CNT_W'(1);
              state_d = StRun;
            end
            default: begin
              b_d     = bus.cmd_data;
              m_d     = bus.cmd_mode;
              cnt_d   = bus.cmd_cnt;
              state_d = (bus.cmd_cnt == '0) ? StDone : StRun;
            end
          endcase
        end
      end
      StRun: begin
        acc_d = alu_r;
        // Gate before OR so a floating carry never reaches the sticky flag.
        if (ovf_mode(m_q)) begin
          ovf_d = ovf_q | alu_ovf;
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.res_valid = (state_q == StDone);
  assign bus.res_data  = acc_q;
  assign bus.res_ovf   = ovf_q;

  assign alu_a = acc_q;
  assign alu_b = b_q;
  assign alu_m = m_q;

endmodule
